ram_stream_fifo: RTL and testbench

RAM_STREAM_FIFO -- requirements
Module: ram_stream_fifo

---
 rtl/ram_stream_fifo.sv | 182 ++++++++++++++++++
 tb/tb_ram_stream_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_fifo.sv
// ram_stream_fifo: streaming FIFO on a single-read-port synchronous RAM with
// a two-entry output stage (head + skid) so push/pop run at one per cycle.
// Optional almost-full/almost-empty flags: define RAM_STREAM_FIFO_ALMOST_FLAGS_EN.
// Without the macro both flag ports are tied low.

// Single-read-port synchronous RAM, one-cycle registered read, no reset.
module sync_ram #(
  parameter int MEM_SIZE   = 16,
  parameter int DATA_WIDTH = 8,
  localparam int AW        = $clog2(MEM_SIZE)
) (
  input  logic                  clock,
  input  logic                  write_en,
  input  logic [AW-1:0]         write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  input  logic [AW-1:0]         read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  // write port and registered read port
  always_ff @(posedge clock) begin
    if (write_en) mem[write_addr] <= write_data;
    if (read_en)  read_data       <= mem[read_addr];
  end

endmodule

module ram_stream_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iPushValid,
  input  logic [DATA_WIDTH-1:0] iPushData,
  output logic                  oPushReady,
  output logic                  oPopValid,
  output logic [DATA_WIDTH-1:0] oPopData,
  input  logic                  iPopReady,
  output logic [ADDR_WIDTH:0]   oLevel,
  output logic                  oAlmostFull,
  output logic                  oAlmostEmpty
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic [ADDR_WIDTH:0]   level_next;
  logic [ADDR_WIDTH:0]   ram_unread;
  logic [1:0]            stage_after_pop;
  logic                  rd_inflight;
  logic                  rd_en;
  logic                  push;
  logic                  pop;
  logic                  head_valid;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Ready depends only on the registered level, never on iPopReady.
  assign oPushReady = (level < FULL_LEVEL);
  assign push       = iPushValid & oPushReady;
  assign pop        = head_valid & iPopReady;
  assign oPopValid  = head_valid;
  assign oPopData   = head_data;
  assign oLevel     = level;

  // Read scheduling: data still in RAM is the level minus what sits in the
  // output stage or the read pipeline. A read issued now lands two edges
  // later, so it may go if the stage (after this cycle's pop) plus the read
  // already in flight leaves at least one slot.
  always_comb begin
    ram_unread = level
               - (ADDR_WIDTH+1)'(head_valid)
               - (ADDR_WIDTH+1)'(skid_valid)
               - (ADDR_WIDTH+1)'(rd_inflight);
    stage_after_pop = 2'(head_valid) + 2'(skid_valid) + 2'(rd_inflight) - 2'(pop);
    rd_en = (ram_unread != '0) && (stage_after_pop < 2'd2);
  end

  // Level bookkeeping: simultaneous push and pop cancel out.
  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + (ADDR_WIDTH+1)'(1);
      2'b01:   level_next = level - (ADDR_WIDTH+1)'(1);
      default: level_next = level;
    endcase
  end

  // Pointers, level and read-in-flight flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      level       <= level_next;
      rd_inflight <= rd_en;
    end
  end

  // Output stage: returning read data fills head first, then skid; a pop
  // shifts skid into head. Head data is frozen while stalled.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (pop) begin
      if (skid_valid) begin
        head_data  <= skid_data;
        head_valid <= 1'b1;
        skid_valid <= rd_inflight;
        if (rd_inflight) skid_data <= ram_rdata;
      end else begin
        head_valid <= rd_inflight;
        if (rd_inflight) head_data <= ram_rdata;
      end
    end else if (rd_inflight) begin
      if (!head_valid) begin
        head_valid <= 1'b1;
        head_data  <= ram_rdata;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= ram_rdata;
      end
    end
  end

  sync_ram #(
    .MEM_SIZE   (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clock      (Clock),
    .write_en   (push),
    .write_addr (wr_ptr),
    .write_data (iPushData),
    .read_en    (rd_en),
    .read_addr  (rd_ptr),
    .read_data  (ram_rdata)
  );

`ifdef RAM_STREAM_FIFO_ALMOST_FLAGS_EN
  localparam logic [ADDR_WIDTH:0] AF_THRESH = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_THRESH = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic almost_full;
  logic almost_empty;

  // Threshold flags track the level register on the same edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (level_next >= AF_THRESH);
      almost_empty <= (level_next <= AE_THRESH);
    end
  end

  assign oAlmostFull  = almost_full;
  assign oAlmostEmpty = almost_empty;
`else
  assign oAlmostFull  = 1'b0;
  assign oAlmostEmpty = 1'b0;
`endif

endmodule

// File: tb/tb_ram_stream_fifo.sv
// Bench for ram_stream_fifo: directed steps plus random traffic checked
// against a queue model of the FIFO contents.
module tb_ram_stream_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          iPushValid = 1'b0;
  logic [DW-1:0] iPushData = '0;
  logic          oPushReady;
  logic          oPopValid;
  logic [DW-1:0] oPopData;
  logic          iPopReady = 1'b0;
  logic [AW:0]   oLevel;
  logic          oAlmostFull;
  logic          oAlmostEmpty;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q [$];
  int cyc = 0;
  int pops_seen = 0;
  int first_pop_cyc = -1;
  int last_pop_cyc = -1;

  ram_stream_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iPushValid   (iPushValid),
    .iPushData    (iPushData),
    .oPushReady   (oPushReady),
    .oPopValid    (oPopValid),
    .oPopData     (oPopData),
    .iPopReady    (iPopReady),
    .oLevel       (oLevel),
    .oAlmostFull  (oAlmostFull),
    .oAlmostEmpty (oAlmostEmpty)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":level"}, 32'(oLevel), 32'(q.size()));
    chk({tag, ":push_ready"}, 32'(oPushReady), 32'(q.size() < DEPTH));
`ifdef RAM_STREAM_FIFO_ALMOST_FLAGS_EN
    chk({tag, ":almost_full"}, 32'(oAlmostFull), 32'(q.size() >= AF));
    chk({tag, ":almost_empty"}, 32'(oAlmostEmpty), 32'(q.size() <= AE));
`else
    chk({tag, ":almost_full"}, 32'(oAlmostFull), 32'(0));
    chk({tag, ":almost_empty"}, 32'(oAlmostEmpty), 32'(0));
`endif
    if (oPopValid) chk({tag, ":valid_nonempty"}, 32'(q.size() != 0), 32'(1));
  endtask

  // One clock cycle: called at a falling edge, drives inputs, updates the
  // model with the handshakes that happen at the rising edge, then checks.
  task automatic step(input logic pv, input logic [DW-1:0] pd, input logic pr, input string tag);
    logic push_fire;
    logic pop_fire;
    logic [DW-1:0] exp_data;
    iPushValid = pv;
    iPushData  = pd;
    iPopReady  = pr;
    #1;
    push_fire = pv & oPushReady;
    pop_fire  = oPopValid & pr;
    if (pop_fire) begin
      if (q.size() == 0) begin
        chk({tag, ":pop_when_empty"}, 32'(oPopValid), 32'(0));
      end else begin
        exp_data = q.pop_front();
        chk({tag, ":pop_data"}, 32'(oPopData), 32'(exp_data));
      end
      pops_seen++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    if (push_fire) q.push_back(pd);
    @(negedge Clock);
    cyc++;
    check_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int bias_push;
    int bias_pop;
    // reset state
    @(negedge Clock);
    chk("rst_level", 32'(oLevel), 32'(0));
    chk("rst_valid", 32'(oPopValid), 32'(0));
    chk("rst_data", 32'(oPopData), 32'(0));
    check_state("rst");
    Reset = 1'b0;

    // single-entry latency: push at edge N, valid after edge N+2
    step(1'b1, 8'h11, 1'b1, "lat0");
    chk("lat0_valid", 32'(oPopValid), 32'(0));
    step(1'b0, 8'h00, 1'b1, "lat1");
    chk("lat1_valid", 32'(oPopValid), 32'(0));
    step(1'b0, 8'h00, 1'b1, "lat2");
    chk("lat2_valid", 32'(oPopValid), 32'(1));
    chk("lat2_data", 32'(oPopData), 32'(8'h11));
    chk("lat2_level", 32'(oLevel), 32'(1));
    step(1'b0, 8'h00, 1'b1, "lat3");
    chk("lat3_level", 32'(oLevel), 32'(0));

    // fill to full, overflow offer, drain in order
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, "fill");
    chk("full_level", 32'(oLevel), 32'(16));
    chk("full_ready", 32'(oPushReady), 32'(0));
    step(1'b1, 8'hEE, 1'b0, "overflow");
    chk("overflow_level", 32'(oLevel), 32'(16));
    pops_seen = 0;
    for (int k = 0; k < 40 && q.size() > 0; k++) step(1'b0, 8'h00, 1'b1, "drain");
    chk("drain_count", 32'(pops_seen), 32'(16));
    chk("drain_level", 32'(oLevel), 32'(0));

    // continuous streaming across pointer wraps, no bubbles after priming
    pops_seen = 0;
    first_pop_cyc = -1;
    last_pop_cyc = -1;
    for (int i = 0; i < 40; i++) step(1'b1, 8'(i), 1'b1, "stream");
    for (int k = 0; k < 20 && q.size() > 0; k++) step(1'b0, 8'h00, 1'b1, "stream_drain");
    chk("stream_pops", 32'(pops_seen), 32'(40));
    chk("stream_span", 32'(last_pop_cyc - first_pop_cyc), 32'(39));

    // consumer stall holds head data
    step(1'b1, 8'h3C, 1'b0, "stall_fill");
    step(1'b1, 8'h3D, 1'b0, "stall_fill");
    for (int k = 0; k < 10 && !oPopValid; k++) step(1'b0, 8'h00, 1'b0, "stall_wait");
    chk("stall_ready_valid", 32'(oPopValid), 32'(1));
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 8'h00, 1'b0, "stall");
      chk("stall_valid", 32'(oPopValid), 32'(1));
      chk("stall_data", 32'(oPopData), 32'(8'h3C));
    end
    for (int k = 0; k < 10 && q.size() > 0; k++) step(1'b0, 8'h00, 1'b1, "stall_drain");
    chk("stall_drain_level", 32'(oLevel), 32'(0));

    // asynchronous reset mid-operation with seven entries stored
    for (int i = 0; i < 7; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, "prerst");
    chk("prerst_level", 32'(oLevel), 32'(7));
    #2;
    Reset = 1'b1;
    #1;
    q.delete();
    chk("midrst_level", 32'(oLevel), 32'(0));
    chk("midrst_valid", 32'(oPopValid), 32'(0));
    chk("midrst_data", 32'(oPopData), 32'(0));
    check_state("midrst");
    @(negedge Clock);
    Reset = 1'b0;
    step(1'b1, 8'hA5, 1'b1, "postrst_push");
    for (int k = 0; k < 8 && !oPopValid; k++) step(1'b0, 8'h00, 1'b0, "postrst_wait");
    chk("postrst_valid", 32'(oPopValid), 32'(1));
    chk("postrst_first", 32'(oPopData), 32'(8'hA5));
    step(1'b0, 8'h00, 1'b1, "postrst_pop");

    // randomized traffic in phases of different push/pop pressure
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin bias_push = 85; bias_pop = 25; end
        1: begin bias_push = 25; bias_pop = 85; end
        2: begin bias_push = 60; bias_pop = 60; end
        default: begin bias_push = 95; bias_pop = 95; end
      endcase
      for (int k = 0; k < 100; k++)
        step(($urandom_range(0, 99) < bias_push), 8'($urandom), ($urandom_range(0, 99) < bias_pop), "rand");
    end
    for (int k = 0; k < 40 && q.size() > 0; k++) step(1'b0, 8'($urandom), 1'b1, "rand_drain");
    chk("rand_final_level", 32'(oLevel), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
